// File: rtl/accum_share_pkg.sv
// Shared types for the accumulator-sharing controller: FSM states and id-width helper.
package accum_share_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACC,
        DRAIN,
        RESP
    } state_t;

    // Width of an encoded requester id; never below 1 so ports stay legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/accum_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter
    import accum_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                id         = idx;
            end
        end
    end

endmodule

// File: rtl/accum_share_ctrl.sv
// Round-robin owner of a shared adder/accumulator datapath; one requester job at a time.
// Build option: ACC_TIMEOUT_EN ends a stalled job after TIMEOUT_CYCLES idle ACC cycles.
module accum_share_ctrl
    import accum_share_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int W              = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int IDW            = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              dp_clear,
    output logic [W-1:0]      dp_a,
    output logic [W-1:0]      dp_b,
    input  logic [W-1:0]      dp_accum,
    input  logic              dp_cout_accum,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_accum,
    output logic              rsp_overflow,
    output logic              rsp_timeout
);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gid;
    logic [NREQ-1:0] gnt_q;
    logic            ovf_q;
    logic            tmo_q;

    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_id;
    logic            arb_any;

    logic            valid_g;
    logic            last_g;
    logic            hs;
    logic            timeout_hit;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .id    (arb_id),
        .any   (arb_any)
    );

    // The latched one-hot grant selects the owner's operands without a wide index mux.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    assign valid_g   = |(req_valid & gnt_q);
    assign last_g    = |(req_last & gnt_q);
    assign hs        = (state == ACC) && valid_g;
    assign req_ready = (state == ACC) ? gnt_q : '0;
    assign dp_clear  = (state == CLEAR);
    assign dp_a      = hs ? sel_a : '0;
    assign dp_b      = hs ? sel_b : '0;

`ifdef ACC_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != ACC || valid_g)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout_hit = (state == ACC) && !valid_g && (idle_cnt == TCW'(TIMEOUT_CYCLES - 1));
`else
    // The stall limit only matters in the timeout build; folded here to keep it referenced.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // Job sequencer; the sticky carry is sampled from the first ACC cycle through DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            gid          <= '0;
            gnt_q        <= '0;
            ovf_q        <= 1'b0;
            tmo_q        <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_accum    <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gid   <= arb_id;
                        gnt_q <= arb_grant;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    ovf_q <= 1'b0;
                    tmo_q <= 1'b0;
                    state <= ACC;
                end
                ACC: begin
                    ovf_q <= ovf_q | dp_cout_accum;
                    if (hs && last_g) begin
                        state <= DRAIN;
                    end else if (timeout_hit) begin
                        tmo_q <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    rsp_valid    <= 1'b1;
                    rsp_id       <= gid;
                    rsp_accum    <= dp_accum;
                    rsp_overflow <= ovf_q | dp_cout_accum;
                    rsp_timeout  <= tmo_q;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
